arty_reset_sequencer: RTL and testbench

- Parametrised reset and status controller for Arty A7 top levels.
- Generalises the single-domain fixed-count reset pulse into a full sequencer:
  - N reset domains, each released in staggered order.
  - Configurable hold time.
  - Optional wait for memory-calibration-complete, with a timeout.
  - Automatic re-sequencing when calibration is lost.
  - Sticky error collection, cleared per sequence.
- Sits between debounced button/board-reset sources and the FPGA host, the AXI adapter and processor reset inputs.

---
 rtl/arty_reset_sequencer.sv | 130 +++++++++++++
 tb/tb_arty_reset_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arty_reset_sequencer.sv
// Reset sequencer for Arty A7 top levels: holds every domain in reset, optionally
// waits for memory calibration, then releases domains in staggered order.
module arty_reset_sequencer #(
  parameter int num_domains_p     = 3,
  parameter int hold_cycles_p     = 32'h200_0000,
  parameter int stagger_cycles_p  = 16,
  parameter int calib_timeout_p   = 0,
  parameter int auto_recal_p      = 1,
  parameter int num_err_p         = 3,
  parameter int seq_count_width_p = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         reset_req_i,
  input  logic                         calib_done_i,
  input  logic [num_err_p-1:0]         error_i,
  output logic [num_domains_p-1:0]     domain_reset_o,
  output logic                         busy_o,
  output logic [num_err_p-1:0]         err_sticky_o,
  output logic                         calib_timeout_o,
  output logic [seq_count_width_p-1:0] seq_count_o
);

  localparam int CNT_MAX_HS = (hold_cycles_p > stagger_cycles_p) ? hold_cycles_p : stagger_cycles_p;
  localparam int CNT_MAX    = (CNT_MAX_HS > calib_timeout_p) ? CNT_MAX_HS : calib_timeout_p;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);
  localparam int IDX_W      = $clog2(num_domains_p) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(hold_cycles_p - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(stagger_cycles_p - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((calib_timeout_p > 0) ? calib_timeout_p - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(num_domains_p - 1);

  typedef enum logic [1:0] {HOLD, WAIT_CALIB, RELEASE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic             restart;
  logic             timeout_hit;

  function automatic logic [seq_count_width_p-1:0] sat_inc(input logic [seq_count_width_p-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Requests that throw an in-flight or running sequence back to HOLD.
  always_comb begin
    restart = 1'b0;
    case (state)
      WAIT_CALIB, RELEASE: restart = reset_req_i;
      RUN:                 restart = reset_req_i || ((auto_recal_p != 0) && !calib_done_i);
      default:             restart = 1'b0;
    endcase
  end

  assign timeout_hit = (calib_timeout_p > 0) && (cnt == TIMEOUT_LAST);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state           <= HOLD;
      cnt             <= '0;
      idx             <= '0;
      domain_reset_o  <= '1;
      busy_o          <= 1'b1;
      err_sticky_o    <= '0;
      calib_timeout_o <= 1'b0;
      seq_count_o     <= '0;
    end else begin
      err_sticky_o <= err_sticky_o | error_i;
      if (restart) begin
        // Errors seen on the clear edge survive into the new sequence.
        state           <= HOLD;
        cnt             <= '0;
        idx             <= '0;
        domain_reset_o  <= '1;
        busy_o          <= 1'b1;
        err_sticky_o    <= error_i;
        calib_timeout_o <= 1'b0;
      end else begin
        case (state)
          HOLD: begin
            if (reset_req_i) begin
              cnt <= '0;
            end else if (cnt == HOLD_LAST) begin
              state <= WAIT_CALIB;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_CALIB: begin
            if (calib_done_i || timeout_hit) begin
              if (!calib_done_i) calib_timeout_o <= 1'b1;
              domain_reset_o[0] <= 1'b0;
              idx               <= IDX_W'(1);
              cnt               <= '0;
              if (num_domains_p == 1) begin
                state       <= RUN;
                busy_o      <= 1'b0;
                seq_count_o <= sat_inc(seq_count_o);
              end else begin
                state <= RELEASE;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          RELEASE: begin
            if (cnt == STAGGER_LAST) begin
              for (int i = 1; i < num_domains_p; i++) begin
                if (idx == IDX_W'(i)) domain_reset_o[i] <= 1'b0;
              end
              idx <= idx + 1'b1;
              cnt <= '0;
              if (idx == IDX_LAST) begin
                state       <= RUN;
                busy_o      <= 1'b0;
                seq_count_o <= sat_inc(seq_count_o);
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_arty_reset_sequencer.sv
// Bench for arty_reset_sequencer: four configurations, each checked every cycle
// against a sequence-level model plus hand-computed directed expectations.
module tb_arty_reset_sequencer;

  localparam int P_N [4] = '{3, 3, 3, 1};
  localparam int P_H [4] = '{8, 8, 8, 3};
  localparam int P_S [4] = '{4, 4, 4, 1};
  localparam int P_T [4] = '{0, 20, 0, 0};
  localparam int P_A [4] = '{1, 1, 0, 1};
  localparam int P_W [4] = '{8, 8, 2, 8};

  localparam int PH_HOLD = 0, PH_CALIB = 1, PH_REL = 2, PH_RUN = 3;

  typedef struct {
    int         phase;
    int         el;
    int         rel;
    logic [2:0] sticky;
    bit         to;
    int         seq;
  } m_t;

  logic       clk;
  logic       rstn   [4];
  logic       req    [4];
  logic       cal    [4];
  logic [2:0] err    [4];
  logic [2:0] dr_w   [3];
  logic       dr3;
  logic       busy_w [4];
  logic [2:0] st_w   [4];
  logic       to_w   [4];
  logic [7:0] sc0, sc1, sc3;
  logic [1:0] sc2;

  m_t m [4];
  bit cmp_en = 1'b0;
  int n_chk  = 0;
  int n_fail = 0;

  arty_reset_sequencer #(.num_domains_p(3), .hold_cycles_p(8), .stagger_cycles_p(4), .calib_timeout_p(0),
                         .auto_recal_p(1), .num_err_p(3), .seq_count_width_p(8)) d0 (
    .clk_i(clk), .reset_n_i(rstn[0]), .reset_req_i(req[0]), .calib_done_i(cal[0]), .error_i(err[0]),
    .domain_reset_o(dr_w[0]), .busy_o(busy_w[0]), .err_sticky_o(st_w[0]), .calib_timeout_o(to_w[0]),
    .seq_count_o(sc0));

  arty_reset_sequencer #(.num_domains_p(3), .hold_cycles_p(8), .stagger_cycles_p(4), .calib_timeout_p(20),
                         .auto_recal_p(1), .num_err_p(3), .seq_count_width_p(8)) d1 (
    .clk_i(clk), .reset_n_i(rstn[1]), .reset_req_i(req[1]), .calib_done_i(cal[1]), .error_i(err[1]),
    .domain_reset_o(dr_w[1]), .busy_o(busy_w[1]), .err_sticky_o(st_w[1]), .calib_timeout_o(to_w[1]),
    .seq_count_o(sc1));

  arty_reset_sequencer #(.num_domains_p(3), .hold_cycles_p(8), .stagger_cycles_p(4), .calib_timeout_p(0),
                         .auto_recal_p(0), .num_err_p(3), .seq_count_width_p(2)) d2 (
    .clk_i(clk), .reset_n_i(rstn[2]), .reset_req_i(req[2]), .calib_done_i(cal[2]), .error_i(err[2]),
    .domain_reset_o(dr_w[2]), .busy_o(busy_w[2]), .err_sticky_o(st_w[2]), .calib_timeout_o(to_w[2]),
    .seq_count_o(sc2));

  arty_reset_sequencer #(.num_domains_p(1), .hold_cycles_p(3), .stagger_cycles_p(1), .calib_timeout_p(0),
                         .auto_recal_p(1), .num_err_p(3), .seq_count_width_p(8)) d3 (
    .clk_i(clk), .reset_n_i(rstn[3]), .reset_req_i(req[3]), .calib_done_i(cal[3]), .error_i(err[3]),
    .domain_reset_o(dr3), .busy_o(busy_w[3]), .err_sticky_o(st_w[3]), .calib_timeout_o(to_w[3]),
    .seq_count_o(sc3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic m_t m_reset();
    m_t r;
    r.phase = PH_HOLD; r.el = 0; r.rel = 0; r.sticky = '0; r.to = 1'b0; r.seq = 0;
    return r;
  endfunction

  // Sequence-level model: time spent in each phase, domains derived from release time.
  function automatic m_t m_step(m_t s, int k, logic rn, logic rq, logic cd, logic [2:0] e);
    m_t n = s;
    int seq_max = (1 << P_W[k]) - 1;
    if (!rn) return m_reset();
    n.sticky = s.sticky | e;
    if (((s.phase == PH_CALIB || s.phase == PH_REL) && rq) ||
        (s.phase == PH_RUN && (rq || (P_A[k] != 0 && !cd)))) begin
      n = m_reset();
      n.sticky = e;
      n.seq = s.seq;
      return n;
    end
    case (s.phase)
      PH_HOLD: begin
        if (rq) n.el = 0;
        else if (s.el + 1 == P_H[k]) begin n.phase = PH_CALIB; n.el = 0; end
        else n.el = s.el + 1;
      end
      PH_CALIB: begin
        if (cd || (P_T[k] > 0 && s.el + 1 == P_T[k])) begin
          if (!cd) n.to = 1'b1;
          n.el = 0;
          n.rel = 0;
          if (P_N[k] == 1) begin
            n.phase = PH_RUN;
            n.seq = (s.seq < seq_max) ? s.seq + 1 : s.seq;
          end else n.phase = PH_REL;
        end else n.el = s.el + 1;
      end
      PH_REL: begin
        n.rel = s.rel + 1;
        if (n.rel == (P_N[k] - 1) * P_S[k]) begin
          n.phase = PH_RUN;
          n.seq = (s.seq < seq_max) ? s.seq + 1 : s.seq;
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] exp_dom(m_t s, int k);
    logic [31:0] v = '0;
    for (int i = 0; i < P_N[k]; i++) begin
      if (s.phase == PH_HOLD || s.phase == PH_CALIB) v[i] = 1'b1;
      else if (s.phase == PH_REL) v[i] = (s.rel < i * P_S[k]);
    end
    return v;
  endfunction

  function automatic logic [31:0] act_dom(int k);
    return (k == 3) ? {31'b0, dr3} : {29'b0, dr_w[k]};
  endfunction

  function automatic logic [31:0] act_seq(int k);
    case (k)
      0:       return {24'b0, sc0};
      1:       return {24'b0, sc1};
      2:       return {30'b0, sc2};
      default: return {24'b0, sc3};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) m[k] = m_step(m[k], k, rstn[k], req[k], cal[k], err[k]);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("d%0d.domain_reset", k), act_dom(k), exp_dom(m[k], k));
        chk($sformatf("d%0d.busy", k), {31'b0, busy_w[k]}, {31'b0, m[k].phase != PH_RUN});
        chk($sformatf("d%0d.err_sticky", k), {29'b0, st_w[k]}, {29'b0, m[k].sticky});
        chk($sformatf("d%0d.calib_timeout", k), {31'b0, to_w[k]}, {31'b0, m[k].to});
        chk($sformatf("d%0d.seq_count", k), act_seq(k), 32'(m[k].seq));
      end
    end
  end

  initial begin
    int exp_sc [4] = '{2, 3, 3, 3};
    for (int k = 0; k < 4; k++) begin
      rstn[k] = 1'b0; req[k] = 1'b0; cal[k] = 1'b1; err[k] = '0; m[k] = m_reset();
    end
    cal[1] = 1'b0;
    tick(3);
    cmp_en = 1'b1;
    chk("reset dom", {29'b0, dr_w[0]}, 32'b111);
    chk("reset busy", {31'b0, busy_w[0]}, 32'd1);
    chk("reset sticky", {29'b0, st_w[0]}, 32'd0);
    chk("reset timeout", {31'b0, to_w[0]}, 32'd0);
    chk("reset seq", {24'b0, sc0}, 32'd0);

    // Basic release with calibration already done
    rstn[0] = 1'b1;
    tick(8);  chk("t1 hold end dom", {29'b0, dr_w[0]}, 32'b111);
    tick(1);  chk("t1 dom0 rel", {29'b0, dr_w[0]}, 32'b110);
    tick(4);  chk("t1 dom1 rel", {29'b0, dr_w[0]}, 32'b100);
    tick(3);  chk("t1 dom2 held", {29'b0, dr_w[0]}, 32'b100);
    tick(1);  chk("t1 all rel", {29'b0, dr_w[0]}, 32'b000);
    chk("t1 busy low", {31'b0, busy_w[0]}, 32'd0);
    chk("t1 seq", {24'b0, sc0}, 32'd1);

    // Sticky errors and clear-with-set on restart
    err[0] = 3'b010; tick(1); err[0] = '0;
    chk("t5 sticky set", {29'b0, st_w[0]}, 32'b010);
    tick(3); chk("t5 sticky held", {29'b0, st_w[0]}, 32'b010);
    req[0] = 1'b1; err[0] = 3'b001; tick(1); req[0] = 1'b0; err[0] = '0;
    chk("t5 sticky clear+set", {29'b0, st_w[0]}, 32'b001);
    chk("t5 dom reassert", {29'b0, dr_w[0]}, 32'b111);
    chk("t5 busy", {31'b0, busy_w[0]}, 32'd1);

    // Abort during RELEASE
    tick(9); chk("t3 in release", {29'b0, dr_w[0]}, 32'b110);
    req[0] = 1'b1; tick(1); req[0] = 1'b0;
    chk("t3 abort dom", {29'b0, dr_w[0]}, 32'b111);
    chk("t3 abort seq", {24'b0, sc0}, 32'd1);
    tick(8); chk("t3 full hold", {29'b0, dr_w[0]}, 32'b111);
    tick(1); chk("t3 rel again", {29'b0, dr_w[0]}, 32'b110);
    tick(8); chk("t3 done dom", {29'b0, dr_w[0]}, 32'b000);
    chk("t3 seq 2", {24'b0, sc0}, 32'd2);

    // Calibration lost in RUN, then wait forever without timeout
    cal[0] = 1'b0; tick(1);
    chk("t4 recal dom", {29'b0, dr_w[0]}, 32'b111);
    chk("t4 recal busy", {31'b0, busy_w[0]}, 32'd1);
    tick(1000);
    chk("t2 wait forever dom", {29'b0, dr_w[0]}, 32'b111);
    chk("t2 wait forever busy", {31'b0, busy_w[0]}, 32'd1);
    cal[0] = 1'b1;

    // Calibration timeout, then calib_done winning on the timeout edge
    rstn[1] = 1'b1;
    tick(27); chk("t2 before timeout dom", {29'b0, dr_w[1]}, 32'b111);
    chk("t2 before timeout flag", {31'b0, to_w[1]}, 32'd0);
    tick(1);  chk("t2 timeout dom", {29'b0, dr_w[1]}, 32'b110);
    chk("t2 timeout flag", {31'b0, to_w[1]}, 32'd1);
    tick(8);  chk("t2 done dom", {29'b0, dr_w[1]}, 32'b000);
    chk("t2 done seq", {24'b0, sc1}, 32'd1);
    tick(1);  chk("t2 auto recal dom", {29'b0, dr_w[1]}, 32'b111);
    chk("t2 flag cleared", {31'b0, to_w[1]}, 32'd0);
    tick(27); cal[1] = 1'b1;
    tick(1);  chk("t2 calib wins dom", {29'b0, dr_w[1]}, 32'b110);
    chk("t2 calib wins flag", {31'b0, to_w[1]}, 32'd0);

    // No auto re-sequencing; saturating counter; reset mid-HOLD
    rstn[2] = 1'b1;
    tick(17); chk("t4b run dom", {29'b0, dr_w[2]}, 32'b000);
    chk("t4b seq", {30'b0, sc2}, 32'd1);
    cal[2] = 1'b0;
    tick(5); chk("t4b no recal dom", {29'b0, dr_w[2]}, 32'b000);
    chk("t4b no recal busy", {31'b0, busy_w[2]}, 32'd0);
    cal[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req[2] = 1'b1; tick(1); req[2] = 1'b0;
      tick(17);
      chk($sformatf("t6 seq after %0d", i + 2), {30'b0, sc2}, 32'(exp_sc[i]));
    end
    req[2] = 1'b1; tick(1); req[2] = 1'b0;
    err[2] = 3'b101; tick(1); err[2] = '0;
    tick(2);
    chk("t6 sticky before reset", {29'b0, st_w[2]}, 32'b101);
    rstn[2] = 1'b0; tick(1);
    chk("t6 reset dom", {29'b0, dr_w[2]}, 32'b111);
    chk("t6 reset busy", {31'b0, busy_w[2]}, 32'd1);
    chk("t6 reset sticky", {29'b0, st_w[2]}, 32'd0);
    chk("t6 reset seq", {30'b0, sc2}, 32'd0);

    // Single domain goes straight from WAIT_CALIB to RUN
    rstn[3] = 1'b1;
    tick(3); chk("n1 hold dom", {31'b0, dr3}, 32'd1);
    tick(1); chk("n1 run dom", {31'b0, dr3}, 32'd0);
    chk("n1 run busy", {31'b0, busy_w[3]}, 32'd0);
    chk("n1 seq", {24'b0, sc3}, 32'd1);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
